modulo_mef_controle_registrador: RTL and testbench

Producer-side control FSM and buffer that feeds the counter-control FSM.
- Queues incoming data words in a small FIFO and presents the head word on reg_out with Load_Reg/EmptyBuffer.
- Holds the word until the counter side answers with Clear_Reg, then retires it and presents the next.
- Forms the writer end of the Load_Reg/EmptyBuffer/Clear_Reg handshake.

---
 rtl/modulo_mef_controle_registrador_pkg.sv | 18 +
 rtl/modulo_mef_controle_registrador_fifo.sv | 89 ++++++++
 rtl/modulo_mef_controle_registrador.sv | 149 ++++++++++++++
 tb/tb_modulo_mef_controle_registrador.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/modulo_mef_controle_registrador_pkg.sv
// -----------------------------------------------------------------------------
// modulo_mef_controle_registrador_pkg
// Shared definitions for the producer-side register control FSM:
//   - state_t : 2-bit FSM encoding (IDLE/PRESENT/POP; 2'b11 is illegal)
//   - DATA_W_DEF / DEPTH_DEF : default word width and FIFO depth
// -----------------------------------------------------------------------------
package modulo_mef_controle_registrador_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PRESENT = 2'b01,
        ST_POP     = 2'b10
    } state_t;

endpackage : modulo_mef_controle_registrador_pkg

// File: rtl/modulo_mef_controle_registrador_fifo.sv
// -----------------------------------------------------------------------------
// modulo_buffer_fifo
// Small circular FIFO buffering data words for the register control FSM.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (pointers/count only)
//   push_i        : push request (ignored while full)
//   pop_i         : pop request (ignored while empty)
//   wdata_i       : word to enqueue
//   head_o        : word at the read pointer
//   count_o       : number of stored words (0..DEPTH)
//   ready_o       : FIFO not full
// -----------------------------------------------------------------------------
module modulo_buffer_fifo
    import modulo_mef_controle_registrador_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DATA_W-1:0]        wdata_i,
    output logic [DATA_W-1:0]        head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     ready_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_s;
    logic              pop_s;

    assign ready_o = (count_q != FULL_CNT);
    // A push while full is dropped so the stored words are never overwritten.
    assign push_s  = push_i & ready_o;
    assign pop_s   = pop_i & (count_q != CNT_W'(0));
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next-state for pointers and occupancy; pointers wrap naturally (DEPTH is a power of two).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Word storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule : modulo_buffer_fifo

// File: rtl/modulo_mef_controle_registrador.sv
// -----------------------------------------------------------------------------
// modulo_mef_controle_registrador
// Writer end of the Load_Reg / EmptyBuffer / Clear_Reg handshake. Queues
// incoming words and presents the head word on reg_out until the counter side
// acknowledges with Clear_Reg, then retires it and presents the next one.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   enable       : FSM advance enable (pushes are accepted regardless)
//   data_in      : word to enqueue, pushed when data_valid & data_ready
//   data_valid   : push request
//   data_ready   : FIFO not full
//   Clear_Reg    : consumer acknowledge of the presented word
//   Load_Reg     : a word is being presented on reg_out
//   EmptyBuffer  : FIFO holds no words
//   reg_out      : registered copy of the presented word
//   count        : words stored
//   overflow     : sticky push-while-full flag
// Build option: define OVERFLOW_FLAG_EN to build the sticky overflow flag;
// otherwise overflow is constant 0.
// -----------------------------------------------------------------------------
module modulo_mef_controle_registrador
    import modulo_mef_controle_registrador_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     data_valid,
    output logic                     data_ready,
    input  logic                     Clear_Reg,
    output logic                     Load_Reg,
    output logic                     EmptyBuffer,
    output logic [DATA_W-1:0]        reg_out,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] reg_out_q, reg_out_d;
    logic [DATA_W-1:0] head_s;
    logic [CNT_W-1:0]  count_s;
    logic              ready_s;
    logic              pop_s;
    logic              capture_s;

    modulo_buffer_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (data_valid),
        .pop_i   (pop_s),
        .wdata_i (data_in),
        .head_o  (head_s),
        .count_o (count_s),
        .ready_o (ready_s)
    );

    // FSM next-state: one pop per PRESENT visit, with POP forcing a Load_Reg-low gap.
    always_comb begin
        state_d   = state_q;
        pop_s     = 1'b0;
        capture_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable && (count_s != CNT_W'(0))) begin
                    state_d   = ST_PRESENT;
                    capture_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRESENT: begin
                if (enable && Clear_Reg) begin
                    state_d = ST_POP;
                end else begin
                    state_d = ST_PRESENT;
                end
            end
            ST_POP: begin
                if (enable) begin
                    state_d = ST_IDLE;
                    pop_s   = 1'b1;
                end else begin
                    state_d = ST_POP;
                end
            end
            // The unused encoding recovers regardless of enable.
            default: state_d = ST_IDLE;
        endcase
    end

    // reg_out only changes when the head word is captured on entry to PRESENT.
    always_comb begin
        if (capture_s) begin
            reg_out_d = head_s;
        end else begin
            reg_out_d = reg_out_q;
        end
    end

    // State and presented-word registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            reg_out_q <= DATA_W'(0);
        end else begin
            state_q   <= state_d;
            reg_out_q <= reg_out_d;
        end
    end

    assign Load_Reg    = (state_q == ST_PRESENT);
    assign EmptyBuffer = (count_s == CNT_W'(0));
    assign data_ready  = ready_s;
    assign count       = count_s;
    assign reg_out     = reg_out_q;

`ifdef OVERFLOW_FLAG_EN
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic overflow_q, overflow_d;

    // Sticky: any push attempt while full sets the flag until reset.
    always_comb begin
        overflow_d = overflow_q | (data_valid & (count_s == FULL_CNT));
    end

    // Overflow flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

endmodule : modulo_mef_controle_registrador

// File: tb/tb_modulo_mef_controle_registrador.sv
// -----------------------------------------------------------------------------
// tb_modulo_mef_controle_registrador
// Self-checking bench: directed scenarios followed by randomized traffic, all
// compared against a queue-based reference model of the handshake.
// -----------------------------------------------------------------------------
module tb_modulo_mef_controle_registrador;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic             clk;
    logic             rst;
    logic             enable;
    logic [DATA_W-1:0] data_in;
    logic             data_valid;
    logic             data_ready;
    logic             Clear_Reg;
    logic             Load_Reg;
    logic             EmptyBuffer;
    logic [DATA_W-1:0] reg_out;
    logic [2:0]       count;
    logic             overflow;

    int errors = 0;
    int checks = 0;

    // Reference model: stored words, whether a word is on show, whether it
    // has been acknowledged and awaits retirement, the shown word, the flag.
    logic [DATA_W-1:0] m_q[$];
    bit                m_showing;
    bit                m_acked;
    logic [DATA_W-1:0] m_word;
    bit                m_ovf;

    modulo_mef_controle_registrador #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .Clear_Reg   (Clear_Reg),
        .Load_Reg    (Load_Reg),
        .EmptyBuffer (EmptyBuffer),
        .reg_out     (reg_out),
        .count       (count),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one clock edge's worth of behaviour to the model using current inputs.
    task automatic model_edge();
        int  sz;
        bit  room;
        if (rst) begin
            m_q.delete();
            m_showing = 1'b0;
            m_acked   = 1'b0;
            m_word    = 8'h00;
            m_ovf     = 1'b0;
        end else begin
            sz   = m_q.size();
            room = (sz < DEPTH);
            if (data_valid && sz == DEPTH) m_ovf = 1'b1;
            if (enable) begin
                if (m_acked) begin
                    void'(m_q.pop_front());
                    m_acked = 1'b0;
                end else if (m_showing) begin
                    if (Clear_Reg) begin
                        m_showing = 1'b0;
                        m_acked   = 1'b1;
                    end
                end else if (sz != 0) begin
                    m_showing = 1'b1;
                    m_word    = m_q[0];
                end
            end
            if (data_valid && room) m_q.push_back(data_in);
        end
    endtask

    task automatic check_all();
        logic exp_ovf;
`ifdef OVERFLOW_FLAG_EN
        exp_ovf = m_ovf;
`else
        exp_ovf = 1'b0;
`endif
        chk("Load_Reg",    {31'd0, Load_Reg},    {31'd0, m_showing});
        chk("EmptyBuffer", {31'd0, EmptyBuffer}, {31'd0, (m_q.size() == 0)});
        chk("data_ready",  {31'd0, data_ready},  {31'd0, (m_q.size() < DEPTH)});
        chk("reg_out",     {24'd0, reg_out},     {24'd0, m_word});
        chk("count",       {29'd0, count},       32'(m_q.size()));
        chk("overflow",    {31'd0, overflow},    {31'd0, exp_ovf});
        chk("load_implies_nonempty", {31'd0, (Load_Reg & EmptyBuffer)}, 32'd0);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        logic [DATA_W-1:0] seen[$];
        logic              prev_load;
        rst        = 1'b1;
        enable     = 1'b1;
        data_in    = 8'h00;
        data_valid = 1'b0;
        Clear_Reg  = 1'b0;

        // Reset then idle
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("reset_reg_out", {24'd0, reg_out}, 32'h0);
        chk("reset_empty",   {31'd0, EmptyBuffer}, 32'd1);

        // Single word
        data_valid = 1'b1;
        data_in    = 8'hA5;
        tick();
        data_valid = 1'b0;
        chk("single_count", {29'd0, count}, 32'd1);
        tick();
        chk("single_load", {31'd0, Load_Reg}, 32'd1);
        chk("single_word", {24'd0, reg_out}, 32'hA5);
        Clear_Reg = 1'b1;
        tick();
        Clear_Reg = 1'b0;
        chk("single_ack_low", {31'd0, Load_Reg}, 32'd0);
        tick();
        chk("single_popped", {31'd0, EmptyBuffer}, 32'd1);

        // Ordering with acknowledge of each word
        data_valid = 1'b1;
        data_in = 8'h11; tick();
        data_in = 8'h22; tick();
        data_in = 8'h33; tick();
        data_valid = 1'b0;
        prev_load = 1'b0;
        for (int i = 0; i < 20; i++) begin
            Clear_Reg = Load_Reg;
            if (Load_Reg && !prev_load) seen.push_back(reg_out);
            prev_load = Load_Reg;
            tick();
        end
        Clear_Reg = 1'b0;
        chk("order_n", 32'(seen.size()), 32'd3);
        if (seen.size() == 3) begin
            chk("order_0", {24'd0, seen[0]}, 32'h11);
            chk("order_1", {24'd0, seen[1]}, 32'h22);
            chk("order_2", {24'd0, seen[2]}, 32'h33);
        end

        // Full: five pushes without acknowledge
        data_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            data_in = 8'(i);
            tick();
        end
        data_valid = 1'b0;
        chk("full_count", {29'd0, count}, 32'd4);
        chk("full_ready", {31'd0, data_ready}, 32'd0);
`ifdef OVERFLOW_FLAG_EN
        chk("full_overflow", {31'd0, overflow}, 32'd1);
`else
        chk("full_overflow", {31'd0, overflow}, 32'd0);
`endif
        Clear_Reg = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        Clear_Reg = 1'b0;
        chk("drain_count", {29'd0, count}, 32'd0);
        chk("drain_last",  {24'd0, reg_out}, 32'h04);

        // Simultaneous push and pop
        rst = 1'b1; tick(); rst = 1'b0;
        data_valid = 1'b1;
        data_in = 8'h5A; tick();
        data_in = 8'h6B; tick();
        data_valid = 1'b0;
        chk("simul_present", {24'd0, reg_out}, 32'h5A);
        Clear_Reg = 1'b1; tick(); Clear_Reg = 1'b0;
        data_valid = 1'b1; data_in = 8'h44; tick(); data_valid = 1'b0;
        chk("simul_count", {29'd0, count}, 32'd2);
        tick();
        chk("simul_next", {24'd0, reg_out}, 32'h6B);

        // Freeze while presenting, then reset from PRESENT
        enable = 1'b0;
        Clear_Reg = 1'b1;
        tick(); tick(); tick();
        chk("freeze_load",  {31'd0, Load_Reg}, 32'd1);
        chk("freeze_count", {29'd0, count}, 32'd2);
        Clear_Reg = 1'b0;
        enable = 1'b1;
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_present_load",  {31'd0, Load_Reg}, 32'd0);
        chk("rst_present_count", {29'd0, count}, 32'd0);
        chk("rst_present_word",  {24'd0, reg_out}, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(0, 149) == 0);
            enable     = ($urandom_range(0, 5) != 0);
            data_valid = $urandom_range(0, 1);
            data_in    = 8'($urandom);
            Clear_Reg  = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_modulo_mef_controle_registrador
